vs0_dma: RTL and testbench
==========================

# vs0_dma

Register-programmed word-copy engine that occupies Virtual Socket 0. It takes a 32-bit pipelined Wishbone slave port for configuration and a 32-bit pipelined Wishbone master port toward the crossbar. A transfer copies LEN 32-bit words from SRC to DST, one read/write pair at a time. Completion or bus error raises a level interrupt on `irq_out`.

## Interface
Parameters:
- `ID_VALUE`, default 32'h0000D3A0: value returned by the ID register.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wbs_adr`  in  18  slave word address; only [2:0] are decoded, the upper bits are ignored.
- `wbs_dat_w`  in  32  slave write data.
- `wbs_dat_r`  out  32  slave read data.
- `wbs_sel`  in  4  byte enables; ignored, all accesses are full-word.
- `wbs_cyc`, `wbs_stb`, `wbs_we`  in  1  slave cycle, strobe and write enable.
- `wbs_ack`  out  1  slave acknowledge.
- `wbs_stall`  out  1  slave stall; tied 0.
- `wbs_err`  out  1  slave error; tied 0.
- `wbm_adr_o`  out  28  master word address.
- `wbm_dat_o`  out  32  master write data.
- `wbm_dat_i`  in  32  master read data.
- `wbm_we_o`, `wbm_cyc_o`, `wbm_stb_o`  out  1  master write enable, cycle and strobe.
- `wbm_sel_o`  out  4  master byte enables; 4'hF while `wbm_stb_o` is high, else 0.
- `wbm_ack_i`, `wbm_stall_i`, `wbm_err_i`  in  1  master acknowledge, stall and error.
- `irq_out`  out  1  level interrupt.

## Operation
Register map (word index = `wbs_adr[2:0]`):
- 0 CTRL: bit0 START (write-1 starts a transfer if idle; reads 0); bit1 IRQ_EN (R/W); bit2 FILL (R/W, exists only with the macro, else reads 0).
- 1 STATUS: bit0 BUSY (read-only); bit1 DONE (write-1-to-clear); bit2 ERR (write-1-to-clear).
- 2 SRC [27:0] R/W; 3 DST [27:0] R/W; 4 LEN [15:0] R/W.
- 5 FILLVAL [31:0] R/W (macro only, else reads 0).
- 7 ID: read-only, returns `ID_VALUE`. Unmapped indices read 0; writes to them are ignored.
- Writes to SRC/DST/LEN/CTRL.FILL while BUSY are ignored. START while BUSY is ignored.
- START latches the working address registers `cur_src`, `cur_dst` and `remaining` from SRC, DST and LEN, and clears DONE and ERR. The SRC/DST/LEN registers themselves stay unchanged.
- Master FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE: on START with LEN=0, set DONE and stay in IDLE. Otherwise go to RD_REQ, or to WR_REQ when FILL=1.
- RD_REQ: cyc=1, stb=1, we=0, adr=`cur_src`. Go to RD_WAIT in the cycle where `wbm_stall_i`=0.
- RD_WAIT: cyc=1, stb=0. On ack, latch `wbm_dat_i` and go to WR_REQ.
- WR_REQ: cyc=1, stb=1, we=1, adr=`cur_dst`, dat = latched word (FILLVAL when FILL=1). Go to WR_WAIT when not stalled.
- WR_WAIT: on ack, decrement `remaining` and increment `cur_src` and `cur_dst` by 1 (modulo 2^28, wraps silently).
  - If `remaining` was 1: set DONE and go to IDLE.
  - Otherwise go to RD_REQ, or WR_REQ when FILL=1.
- `wbm_err_i` in either WAIT state: set ERR, go to IDLE, leave DONE clear. Err wins over a simultaneous ack.
- `wbm_cyc_o` stays high continuously from the first RD_REQ/WR_REQ until the cycle IDLE is re-entered.
- BUSY = (state != IDLE).
- `irq_out` = IRQ_EN & (DONE | ERR), registered.

## Timing
- Reset values: every register, the working registers and all outputs are 0, state is IDLE, and `irq_out`=0. Reset asserted mid-transfer aborts the transfer immediately and asynchronously; no DONE or ERR is set.
- Slave: `wbs_ack` is asserted in the cycle after `wbs_stb & wbs_cyc`. Read data is registered and valid with the ack. Register writes take effect on the ack edge. A START write transitions the FSM on the following cycle.
- Master per-word cost with a zero-wait slave (ack in the cycle after the accepted strobe):
  - copy: 4 cycles (RD_REQ, RD_WAIT, WR_REQ, WR_WAIT).
  - fill: 2 cycles.
  - Each stall cycle or ack-wait cycle adds 1.
- DONE/ERR become visible in STATUS, and `irq_out` rises, 1 cycle after the final ack/err edge.
- If a slave W1C write to DONE/ERR coincides with the hardware setting the same bit, the set wins.

## Configuration
- `VS0_DMA_FILL_EN` defined: CTRL.FILL and FILLVAL exist. With FILL=1, reads are skipped and FILLVAL is written to LEN consecutive words starting at DST.
- Not defined: FILL and FILLVAL are absent (read 0, writes ignored), and only copy transfers exist.

## Test plan
- Reset, then read ID -> 32'h0000D3A0. STATUS -> 0. `irq_out`=0.
- SRC=0x100, DST=0x200, LEN=4, IRQ_EN=1, START; memory model returns 0xA0+i with zero-wait ack -> writes to 0x200..0x203 carry 0xA0..0xA3; DONE set; `irq_out`=1; total 16 master cycles from first stb to DONE.
- LEN=0, START -> no `wbm_cyc_o` activity; DONE=1 on the next cycle.
- `wbm_err_i` on the second read of LEN=3 -> ERR=1, DONE=0, `wbm_cyc_o` low the next cycle, only 1 write issued. Writing 0x4 to STATUS then clears ERR and drops `irq_out`.
- Hold `wbm_stall_i`=1 for 3 cycles during WR_REQ -> stb, adr and dat stay stable. SRC=0x0FFFFFFF with LEN=2 -> second read address is 0x0000000.
- With `VS0_DMA_FILL_EN`: FILL=1, FILLVAL=0xDEADBEEF, DST=0x40, LEN=3 -> 3 writes of 0xDEADBEEF to 0x40..0x42, no reads, 6 cycles.

Source files
------------

// File: rtl/vs0_dma.sv
// vs0_dma: register-programmed Wishbone word-copy engine occupying Virtual Socket 0.
// Define VS0_DMA_FILL_EN to add FILL mode (CTRL.FILL and the FILLVAL register).
module vs0_dma #(
  parameter logic [31:0] ID_VALUE = 32'h0000D3A0
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [17:0] wbs_adr,
  input  logic [31:0] wbs_dat_w,
  output logic [31:0] wbs_dat_r,
  input  logic [3:0]  wbs_sel,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        wbs_err,
  output logic [27:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_err_i,
  output logic        irq_out
);

  typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait} state_e;

  state_e      state_q, state_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [27:0] src_q, src_d;
  logic [27:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [27:0] cur_src_q, cur_src_d;
  logic [27:0] cur_dst_q, cur_dst_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] data_q, data_d;
  logic        irq_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;

  logic        slv_acc, slv_wr, busy, start;
  logic [2:0]  reg_idx;
  logic        unused_ok;

  assign slv_acc   = wbs_stb & wbs_cyc;
  assign slv_wr    = slv_acc & wbs_we;
  assign reg_idx   = wbs_adr[2:0];
  assign busy      = (state_q != StIdle);
  assign start     = slv_wr && (reg_idx == 3'd0) && wbs_dat_w[0] && !busy;
  assign unused_ok = ^{wbs_sel, wbs_adr[17:3], wbs_dat_w[31:28]};

  assign wbs_ack   = ack_q;
  assign wbs_dat_r = rdata_q;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;
  assign irq_out   = irq_q;

  // fill_nxt includes a same-cycle CTRL write so START+FILL in one write selects fill mode.
  logic        fill_cur, fill_nxt;
  logic [31:0] fillval;
`ifdef VS0_DMA_FILL_EN
  logic        fill_q;
  logic [31:0] fillval_q, fillval_d;
  always_comb begin
    fill_nxt  = fill_q;
    fillval_d = fillval_q;
    if (slv_wr && (reg_idx == 3'd0) && !busy) fill_nxt = wbs_dat_w[2];
    if (slv_wr && (reg_idx == 3'd5)) fillval_d = wbs_dat_w;
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      fillval_q <= '0;
    end else begin
      fill_q    <= fill_nxt;
      fillval_q <= fillval_d;
    end
  end
  assign fill_cur = fill_q;
  assign fillval  = fillval_q;
`else
  assign fill_cur = 1'b0;
  assign fill_nxt = 1'b0;
  assign fillval  = '0;
`endif

  always_comb begin
    state_d     = state_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    remaining_d = remaining_q;
    data_d      = data_q;

    if (slv_wr) begin
      case (reg_idx)
        3'd0: irq_en_d = wbs_dat_w[1];
        3'd1: begin
          if (wbs_dat_w[1]) done_d = 1'b0;
          if (wbs_dat_w[2]) err_d  = 1'b0;
        end
        3'd2: if (!busy) src_d = wbs_dat_w[27:0];
        3'd3: if (!busy) dst_d = wbs_dat_w[27:0];
        3'd4: if (!busy) len_d = wbs_dat_w[15:0];
        default: ;
      endcase
    end

    if (start) begin
      cur_src_d   = src_q;
      cur_dst_d   = dst_q;
      remaining_d = len_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end

    // Hardware sets below come after the W1C clears so a coinciding set wins.
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_q == 16'd0) done_d = 1'b1;
          else                state_d = fill_nxt ? StWrReq : StRdReq;
        end
      end
      StRdReq: if (!wbm_stall_i) state_d = StRdWait;
      StRdWait: begin
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (wbm_ack_i) begin
          data_d  = wbm_dat_i;
          state_d = StWrReq;
        end
      end
      StWrReq: if (!wbm_stall_i) state_d = StWrWait;
      StWrWait: begin
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (wbm_ack_i) begin
          remaining_d = remaining_q - 16'd1;
          cur_src_d   = cur_src_q + 28'd1;
          cur_dst_d   = cur_dst_q + 28'd1;
          if (remaining_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = fill_cur ? StWrReq : StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (slv_acc) begin
      case (reg_idx)
        3'd0:    rdata_d = {29'd0, fill_cur, irq_en_q, 1'b0};
        3'd1:    rdata_d = {29'd0, err_q, done_q, busy};
        3'd2:    rdata_d = {4'd0, src_q};
        3'd3:    rdata_d = {4'd0, dst_q};
        3'd4:    rdata_d = {16'd0, len_q};
        3'd5:    rdata_d = fillval;
        3'd7:    rdata_d = ID_VALUE;
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    wbm_cyc_o = busy;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    case (state_q)
      StRdReq: begin
        wbm_stb_o = 1'b1;
        wbm_adr_o = cur_src_q;
      end
      StWrReq: begin
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = cur_dst_q;
        wbm_dat_o = fill_cur ? fillval : data_q;
      end
      default: ;
    endcase
    wbm_sel_o = wbm_stb_o ? 4'hF : 4'h0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      irq_q       <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      irq_q       <= irq_en_d & (done_d | err_d);
      ack_q       <= slv_acc;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_vs0_dma.sv
// tb_vs0_dma: self-checking bench for vs0_dma with a Wishbone memory responder and
// a transfer-level reference model (expected address/data lists from SRC, DST, LEN).
module tb_vs0_dma;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] wbs_adr;
  logic [31:0] wbs_dat_w, wbs_dat_r;
  logic [3:0]  wbs_sel;
  logic        wbs_cyc, wbs_stb, wbs_we, wbs_ack, wbs_stall, wbs_err;
  logic [27:0] wbm_adr_o;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_stall_i, wbm_err_i;
  logic        irq_out;

  vs0_dma dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .wbs_adr    (wbs_adr),
    .wbs_dat_w  (wbs_dat_w),
    .wbs_dat_r  (wbs_dat_r),
    .wbs_sel    (wbs_sel),
    .wbs_cyc    (wbs_cyc),
    .wbs_stb    (wbs_stb),
    .wbs_we     (wbs_we),
    .wbs_ack    (wbs_ack),
    .wbs_stall  (wbs_stall),
    .wbs_err    (wbs_err),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_we_o   (wbm_we_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_stall_i(wbm_stall_i),
    .wbm_err_i  (wbm_err_i),
    .irq_out    (irq_out)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder controls and logs
  int          stall_left = 0;
  bit          rand_wait = 0;
  int          err_on_read = -1;
  int          cyc_cycles = 0;
  int          extra_waits = 0;
  logic [31:0] mem_ofs = 32'd0;
  logic [27:0] rd_log[$];
  logic [27:0] wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  bit          pend = 0;
  bit          pend_we = 0;
  logic [27:0] pend_adr = '0;
  int          wait_left = 0;

  // Stall only write requests, and only while a stall budget is armed.
  assign wbm_stall_i = (stall_left != 0) && wbm_stb_o && wbm_we_o;

  function automatic logic [31:0] mem_word(input logic [27:0] a);
    return {4'h0, a} + mem_ofs;
  endfunction

  initial begin : responder
    bit          stalled, acc, prev_stalled;
    logic [27:0] prev_adr;
    logic [31:0] prev_dat;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = '0;
    prev_stalled = 1'b0;
    prev_adr = '0;
    prev_dat = '0;
    forever begin
      @(negedge sys_clk);
      stalled = wbm_stall_i;
      acc = wbm_stb_o && !wbm_stall_i;
      if (wbm_cyc_o) cyc_cycles++;
      n_cmp++;
      if (wbm_sel_o !== (wbm_stb_o ? 4'hF : 4'h0)) begin
        n_bad++;
        $display("FAIL sel: got %h with stb=%b", wbm_sel_o, wbm_stb_o);
      end
      if (prev_stalled) begin
        n_cmp++;
        if (wbm_stb_o !== 1'b1 || wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat) begin
          n_bad++;
          $display("FAIL stall_hold: stb=%b adr=%h dat=%h want stb=1 adr=%h dat=%h",
                   wbm_stb_o, wbm_adr_o, wbm_dat_o, prev_adr, prev_dat);
        end
      end
      prev_stalled = stalled;
      prev_adr = wbm_adr_o;
      prev_dat = wbm_dat_o;
      if (acc) begin
        pend = 1'b1;
        pend_we = wbm_we_o;
        pend_adr = wbm_adr_o;
        wait_left = rand_wait ? int'($urandom_range(0, 2)) : 0;
        extra_waits += wait_left;
        if (wbm_we_o) begin
          wr_adr_log.push_back(wbm_adr_o);
          wr_dat_log.push_back(wbm_dat_o);
        end else begin
          rd_log.push_back(wbm_adr_o);
        end
      end
      @(posedge sys_clk);
      #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      if (stalled && stall_left > 0) stall_left--;
      if (pend) begin
        if (wait_left == 0) begin
          pend = 1'b0;
          if (!pend_we && rd_log.size() == err_on_read) begin
            wbm_err_i = 1'b1;
          end else begin
            wbm_ack_i = 1'b1;
            if (!pend_we) wbm_dat_i = mem_word(pend_adr);
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    wbs_adr = {15'($urandom), a};
    wbs_sel = 4'($urandom);
    wbs_dat_w = d;
    wbs_we = 1'b1;
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    @(posedge sys_clk);
    #1;
    wbs_stb = 1'b0;
    wbs_cyc = 1'b0;
    wbs_we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d, output logic ak);
    wbs_adr = {15'($urandom), a};
    wbs_we = 1'b0;
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    @(posedge sys_clk);
    #1;
    d = wbs_dat_r;
    ak = wbs_ack;
    wbs_stb = 1'b0;
    wbs_cyc = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (!wbm_cyc_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_transfer(input logic [27:0] s, input logic [27:0] d,
                                input logic [15:0] n, input logic [31:0] ctrl);
    wb_write(3'd2, {4'hA, s});
    wb_write(3'd3, {4'h5, d});
    wb_write(3'd4, {16'hBEEF, n});
    rd_log.delete();
    wr_adr_log.delete();
    wr_dat_log.delete();
    cyc_cycles = 0;
    extra_waits = 0;
    wb_write(3'd0, ctrl);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic ak;
    wbs_adr = '0; wbs_dat_w = '0; wbs_sel = '0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({irq_out, wbm_cyc_o, wbm_stb_o, wbs_ack, wbs_stall, wbs_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outs: irq=%b cyc=%b stb=%b ack=%b stall=%b err=%b want all 0",
               irq_out, wbm_cyc_o, wbm_stb_o, wbs_ack, wbs_stall, wbs_err);
    end
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    wb_read(3'd7, d, ak);
    n_cmp++;
    if (d !== 32'h0000D3A0 || ak !== 1'b1) begin
      n_bad++;
      $display("FAIL id: got %h ack=%b want 0000d3a0 ack=1", d, ak);
    end
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
    wb_read(3'd2, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL reset_src: got %h want 0", d); end
  endtask

  task automatic test_regs;
    logic [31:0] s, t, n, d;
    logic ak;
    s = $urandom; t = $urandom; n = $urandom;
    wb_write(3'd2, s);
    wb_write(3'd3, t);
    wb_write(3'd4, n);
    wb_write(3'd6, 32'hFFFF_FFFF);
    wb_write(3'd0, 32'h2);
    wb_read(3'd2, d, ak);
    n_cmp++;
    if (d !== {4'h0, s[27:0]}) begin n_bad++; $display("FAIL src_rb: got %h want %h", d, {4'h0, s[27:0]}); end
    wb_read(3'd3, d, ak);
    n_cmp++;
    if (d !== {4'h0, t[27:0]}) begin n_bad++; $display("FAIL dst_rb: got %h want %h", d, {4'h0, t[27:0]}); end
    wb_read(3'd4, d, ak);
    n_cmp++;
    if (d !== {16'h0, n[15:0]}) begin n_bad++; $display("FAIL len_rb: got %h want %h", d, {16'h0, n[15:0]}); end
    wb_read(3'd6, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped: got %h want 0", d); end
    wb_read(3'd0, d, ak);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL ctrl_rb: got %h want 2", d); end
  endtask

  task automatic test_copy;
    logic [27:0] s, t, e;
    logic [15:0] n;
    logic [31:0] d;
    logic ak;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        s = 28'h100; t = 28'h200; n = 16'd4;
        mem_ofs = 32'hA0 - 32'h100;
        rand_wait = 1'b0;
      end else begin
        s = 28'($urandom); t = 28'($urandom); n = 16'($urandom_range(1, 6));
        mem_ofs = $urandom;
        rand_wait = 1'b1;
      end
      start_transfer(s, t, n, 32'h3);
      wait_idle(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL copy_timeout: iter %0d never idle", it); end
      n_cmp++;
      if (irq_out !== 1'b1) begin n_bad++; $display("FAIL copy_irq: got %b want 1", irq_out); end
      n_cmp++;
      if (wr_adr_log.size() != int'(n) || rd_log.size() != int'(n)) begin
        n_bad++;
        $display("FAIL copy_count: reads %0d writes %0d want %0d", rd_log.size(),
                 wr_adr_log.size(), n);
      end
      for (int i = 0; i < int'(n) && i < wr_adr_log.size() && i < rd_log.size(); i++) begin
        e = s + 28'(i);
        n_cmp++;
        if (rd_log[i] !== e || wr_adr_log[i] !== t + 28'(i) || wr_dat_log[i] !== mem_word(e)) begin
          n_bad++;
          $display("FAIL copy_word%0d: rd %h wr %h/%h want rd %h wr %h/%h", i, rd_log[i],
                   wr_adr_log[i], wr_dat_log[i], e, t + 28'(i), mem_word(e));
        end
      end
      n_cmp++;
      if (cyc_cycles != 4 * int'(n) + extra_waits) begin
        n_bad++;
        $display("FAIL copy_cycles: got %0d want %0d", cyc_cycles, 4 * int'(n) + extra_waits);
      end
      wb_read(3'd1, d, ak);
      n_cmp++;
      if (d !== 32'h2) begin n_bad++; $display("FAIL copy_status: got %h want 2", d); end
      wb_write(3'd1, 32'h2);
      wb_read(3'd1, d, ak);
      n_cmp++;
      if (d !== 32'h0 || irq_out !== 1'b0) begin
        n_bad++;
        $display("FAIL done_w1c: status %h irq %b want 0 0", d, irq_out);
      end
    end
    rand_wait = 1'b0;
  endtask

  task automatic test_len_zero;
    logic [31:0] d;
    logic ak;
    start_transfer(28'h123, 28'h456, 16'd0, 32'h1);
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL len0_status: got %h want 2", d); end
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if (cyc_cycles != 0) begin n_bad++; $display("FAIL len0_cyc: got %0d cycles want 0", cyc_cycles); end
    wb_write(3'd1, 32'h2);
  endtask

  task automatic test_error;
    logic [31:0] d;
    logic ak;
    bit ok;
    mem_ofs = $urandom;
    err_on_read = 2;
    start_transfer(28'($urandom), 28'($urandom), 16'd3, 32'h3);
    wait_idle(ok);
    err_on_read = -1;
    n_cmp++;
    if (!ok || cyc_cycles != 6) begin
      n_bad++;
      $display("FAIL err_cycles: got %0d idle=%b want 6 idle=1", cyc_cycles, ok);
    end
    n_cmp++;
    if (rd_log.size() != 2 || wr_adr_log.size() != 1) begin
      n_bad++;
      $display("FAIL err_count: reads %0d writes %0d want 2 1", rd_log.size(), wr_adr_log.size());
    end
    n_cmp++;
    if (irq_out !== 1'b1) begin n_bad++; $display("FAIL err_irq: got %b want 1", irq_out); end
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h4) begin n_bad++; $display("FAIL err_status: got %h want 4", d); end
    wb_write(3'd1, 32'h4);
    n_cmp++;
    if (irq_out !== 1'b0) begin n_bad++; $display("FAIL err_clear_irq: got %b want 0", irq_out); end
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL err_clear: got %h want 0", d); end
  endtask

  task automatic test_stall_wrap;
    logic [27:0] t;
    bit ok;
    mem_ofs = $urandom;
    t = 28'($urandom);
    stall_left = 3;
    start_transfer(28'hFFFFFFF, t, 16'd2, 32'h1);
    wait_idle(ok);
    n_cmp++;
    if (!ok || cyc_cycles != 11) begin
      n_bad++;
      $display("FAIL stall_cycles: got %0d idle=%b want 11 idle=1", cyc_cycles, ok);
    end
    n_cmp++;
    if (rd_log.size() != 2 || wr_adr_log.size() != 2) begin
      n_bad++;
      $display("FAIL wrap_count: reads %0d writes %0d want 2 2", rd_log.size(), wr_adr_log.size());
    end else begin
      n_cmp++;
      if (rd_log[1] !== 28'h0 || wr_dat_log[1] !== mem_word(28'h0)) begin
        n_bad++;
        $display("FAIL wrap_addr: rd %h dat %h want 0000000 %h", rd_log[1], wr_dat_log[1],
                 mem_word(28'h0));
      end
    end
    stall_left = 0;
    wb_write(3'd1, 32'h6);
  endtask

  task automatic test_fill;
    logic [31:0] d, fv;
    logic [27:0] t;
    logic [15:0] n;
    logic ak;
    bit ok;
`ifdef VS0_DMA_FILL_EN
    for (int it = 0; it < 2; it++) begin
      fv = (it == 0) ? 32'hDEADBEEF : $urandom;
      t = (it == 0) ? 28'h40 : 28'($urandom);
      n = (it == 0) ? 16'd3 : 16'($urandom_range(1, 5));
      wb_write(3'd5, fv);
      start_transfer(28'($urandom), t, n, 32'h7);
      wait_idle(ok);
      n_cmp++;
      if (!ok || cyc_cycles != 2 * int'(n)) begin
        n_bad++;
        $display("FAIL fill_cycles: got %0d idle=%b want %0d", cyc_cycles, ok, 2 * int'(n));
      end
      n_cmp++;
      if (rd_log.size() != 0 || wr_adr_log.size() != int'(n)) begin
        n_bad++;
        $display("FAIL fill_count: reads %0d writes %0d want 0 %0d", rd_log.size(),
                 wr_adr_log.size(), n);
      end
      for (int i = 0; i < int'(n) && i < wr_adr_log.size(); i++) begin
        n_cmp++;
        if (wr_adr_log[i] !== t + 28'(i) || wr_dat_log[i] !== fv) begin
          n_bad++;
          $display("FAIL fill_word%0d: %h/%h want %h/%h", i, wr_adr_log[i], wr_dat_log[i],
                   t + 28'(i), fv);
        end
      end
      wb_read(3'd0, d, ak);
      n_cmp++;
      if (d !== 32'h6) begin n_bad++; $display("FAIL fill_ctrl: got %h want 6", d); end
      wb_write(3'd1, 32'h6);
    end
    wb_write(3'd0, 32'h2);
`else
    fv = $urandom;
    wb_write(3'd5, fv);
    wb_write(3'd0, 32'h6);
    wb_read(3'd0, d, ak);
    n_cmp++;
    if (d !== 32'h2) begin n_bad++; $display("FAIL nofill_ctrl: got %h want 2", d); end
    wb_read(3'd5, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL nofill_val: got %h want 0", d); end
    t = '0;
    n = '0;
    ok = 1'b0;
`endif
  endtask

  task automatic test_busy_guard;
    logic [27:0] s, t;
    logic [31:0] d;
    logic ak;
    bit ok;
    s = 28'($urandom); t = 28'($urandom);
    rand_wait = 1'b1;
    start_transfer(s, t, 16'd3, 32'h1);
    wb_write(3'd2, $urandom);
    wb_write(3'd4, 32'h7);
    wb_write(3'd0, 32'h1);
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h1) begin n_bad++; $display("FAIL busy_status: got %h want 1", d); end
    wait_idle(ok);
    rand_wait = 1'b0;
    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if (!ok || wr_adr_log.size() != 3) begin
      n_bad++;
      $display("FAIL busy_restart: writes %0d idle=%b want 3 idle=1", wr_adr_log.size(), ok);
    end
    wb_read(3'd2, d, ak);
    n_cmp++;
    if (d !== {4'h0, s}) begin n_bad++; $display("FAIL busy_src: got %h want %h", d, {4'h0, s}); end
    wb_read(3'd4, d, ak);
    n_cmp++;
    if (d !== 32'h3) begin n_bad++; $display("FAIL busy_len: got %h want 3", d); end
    wb_write(3'd1, 32'h6);
  endtask

  task automatic test_reset_abort;
    logic [31:0] d;
    logic ak;
    start_transfer(28'($urandom), 28'($urandom), 16'd8, 32'h3);
    repeat (5) @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || irq_out !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_async: cyc=%b stb=%b irq=%b want 0 0 0", wbm_cyc_o, wbm_stb_o, irq_out);
    end
    @(negedge sys_clk);
    pend = 1'b0;
    stall_left = 0;
    @(negedge sys_clk);
    pend = 1'b0;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    wb_read(3'd1, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_status: got %h want 0", d); end
    wb_read(3'd2, d, ak);
    n_cmp++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL abort_src: got %h want 0", d); end
  endtask

  initial begin : main
    test_reset;
    test_regs;
    test_copy;
    test_len_zero;
    test_error;
    test_stall_wrap;
    test_fill;
    test_busy_guard;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
